// File: rtl/wires.sv
// Shared pipeline wire and register types for the memory-side path of the core.
// Holds the request/response bundles and the memory arbiter's register state.
package wires;

    localparam int unsigned addr_width = 32;
    localparam int unsigned data_width = 32;
    localparam int unsigned strb_width = data_width / 8;

    typedef struct packed {
        logic                  mem_valid;
        logic                  mem_fence;
        logic                  mem_spec;
        logic                  mem_instr;
        logic [addr_width-1:0] mem_addr;
        logic [data_width-1:0] mem_wdata;
        logic [strb_width-1:0] mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic                  mem_ready;
        logic [data_width-1:0] mem_rdata;
    } mem_out_type;

    typedef enum logic [1:0] {
        IDLE,
        IWAIT,
        DWAIT
    } arbiter_state_type;

    typedef struct packed {
        arbiter_state_type     state;
        logic                  kill;
        logic                  last_d;
        logic [addr_width-1:0] iaddr;
        mem_in_type            mem_in;
    } arbiter_reg_type;

    localparam arbiter_reg_type init_arbiter_reg = '{
        state  : IDLE,
        kill   : 1'b0,
        last_d : 1'b0,
        iaddr  : '0,
        mem_in : '0
    };

    // Data wins a contended grant unless the previous grant already went to data.
    function automatic logic pick_data(input logic d_pending, input logic i_pending,
                                       input logic last_d);
        return d_pending && (!i_pending || !last_d);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and the memory stage, one transaction at a time,
// alternating under contention and discarding responses for redirected fetches.
module mem_arbiter
    import wires::*;
(
    input  logic        reset,
    input  logic        clock,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output mem_in_type  mem_in,
    input  mem_out_type mem_out
);

    arbiter_reg_type r;
    arbiter_reg_type rin;

    always_comb begin
        arbiter_reg_type v;
        logic            arbitrate;
        logic            i_pending;
        logic            d_pending;

        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        v                = r;
        v.mem_in.mem_valid = 1'b0;
        imem_out         = '0;
        dmem_out         = '0;
        arbitrate        = 1'b0;
        i_pending        = imem_in.mem_valid;
        d_pending        = dmem_in.mem_valid;

        case (r.state)
            IDLE: begin
                arbitrate = 1'b1;
            end
            IWAIT: begin
                if (mem_out.mem_ready) begin
                    // A killed fetch keeps its valid high, so its redirected address is still eligible.
                    if (!r.kill) begin
                        imem_out  = mem_out;
                        i_pending = 1'b0;
                    end
                    v.kill    = 1'b0;
                    v.state   = IDLE;
                    arbitrate = 1'b1;
                end else if (imem_in.mem_valid && imem_in.mem_spec &&
                             (imem_in.mem_addr != r.iaddr)) begin
                    v.kill = 1'b1;
                end
            end
            DWAIT: begin
                if (mem_out.mem_ready) begin
                    dmem_out  = mem_out;
                    d_pending = 1'b0;
                    v.state   = IDLE;
                    arbitrate = 1'b1;
                end
            end
            default: begin
                v.state = IDLE;
            end
        endcase

        if (arbitrate) begin
            if (pick_data(d_pending, i_pending, r.last_d)) begin
                v.mem_in           = dmem_in;
                v.mem_in.mem_valid = 1'b1;
                v.mem_in.mem_instr = 1'b0;
                v.last_d           = 1'b1;
                v.state            = DWAIT;
            end else if (i_pending) begin
                v.mem_in           = imem_in;
                v.mem_in.mem_valid = 1'b1;
                v.mem_in.mem_instr = 1'b1;
                v.iaddr            = imem_in.mem_addr;
                v.last_d           = 1'b0;
                v.kill             = 1'b0;
                v.state            = IWAIT;
            end
        end

        // Response ports stay quiet while reset is held, whatever state is left over.
        if (!reset) begin
            imem_out = '0;
            dmem_out = '0;
        end

        rin = v;
    end

    // NOTE: state registers use non-blocking assignment; reset here is synchronous, sampled on clock.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r <= init_arbiter_reg;
        end else begin
            r <= rin;
        end
    end

    assign mem_in = r.mem_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations plus a
// transaction-level model compared against the DUT on every falling edge.
module tb_mem_arbiter;
    import wires::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    mem_in_type  imem_in;
    mem_in_type  dmem_in;
    mem_in_type  mem_in;
    mem_out_type imem_out;
    mem_out_type dmem_out;
    mem_out_type mem_out;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    mem_arbiter dut (
        .reset    (reset),
        .clock    (clock),
        .imem_in  (imem_in),
        .imem_out (imem_out),
        .dmem_in  (dmem_in),
        .dmem_out (dmem_out),
        .mem_in   (mem_in),
        .mem_out  (mem_out)
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: one outstanding owner, a stale flag for redirected fetches,
    // and a fairness flag that favours fetch after a data grant.
    logic       m_known    = 1'b0;
    logic       m_busy     = 1'b0;
    logic       m_is_i     = 1'b0;
    logic       m_stale    = 1'b0;
    logic       m_prefer_i = 1'b0;
    logic [31:0] m_iaddr   = '0;
    mem_in_type m_req      = '0;

    always @(negedge clock) begin
        mem_out_type exp_i;
        mem_out_type exp_d;
        logic        resp;
        logic        want_i;
        logic        want_d;

        exp_i = '0;
        exp_d = '0;
        if (!reset) begin
            check("imem_out_in_reset", 80'(imem_out), 80'(exp_i));
            check("dmem_out_in_reset", 80'(dmem_out), 80'(exp_d));
            m_known    = 1'b1;
            m_busy     = 1'b0;
            m_is_i     = 1'b0;
            m_stale    = 1'b0;
            m_prefer_i = 1'b0;
            m_iaddr    = '0;
            m_req      = '0;
        end else begin
            resp = m_busy && mem_out.mem_ready;
            if (resp && m_is_i && !m_stale) exp_i = mem_out;
            if (resp && !m_is_i) exp_d = mem_out;
            check("model_imem_out", 80'(imem_out), 80'(exp_i));
            check("model_dmem_out", 80'(dmem_out), 80'(exp_d));
            if (m_known) check("model_mem_in", 80'(mem_in), 80'(m_req));

            // The requester currently being served is not a new request until its response is seen.
            want_d = dmem_in.mem_valid && !(m_busy && !m_is_i);
            want_i = imem_in.mem_valid && !(m_busy && m_is_i && !m_stale);
            m_req.mem_valid = 1'b0;
            if (m_busy && m_is_i && !resp && imem_in.mem_valid && imem_in.mem_spec &&
                imem_in.mem_addr != m_iaddr)
                m_stale = 1'b1;
            if (resp) begin
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end
            if (!m_busy) begin
                if (want_d && !(want_i && m_prefer_i)) begin
                    m_req           = dmem_in;
                    m_req.mem_valid = 1'b1;
                    m_req.mem_instr = 1'b0;
                    m_busy          = 1'b1;
                    m_is_i          = 1'b0;
                    m_prefer_i      = 1'b1;
                end else if (want_i) begin
                    m_req           = imem_in;
                    m_req.mem_valid = 1'b1;
                    m_req.mem_instr = 1'b1;
                    m_busy          = 1'b1;
                    m_is_i          = 1'b1;
                    m_stale         = 1'b0;
                    m_iaddr         = imem_in.mem_addr;
                    m_prefer_i      = 1'b0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        imem_in = '0;
        dmem_in = '0;
        mem_out = '0;
    endtask

    initial begin
        int         g;
        logic [3:0] seq;

        idle_inputs();
        reset = 1'b0;
        repeat (3) cyc();
        check("rst_mem_in", 80'(mem_in), 80'd0);
        check("rst_imem_out", 80'(imem_out), 80'd0);
        check("rst_dmem_out", 80'(dmem_out), 80'd0);
        reset = 1'b1;
        cyc();

        // Isolated fetch
        imem_in.mem_valid = 1'b1;
        imem_in.mem_addr  = 32'h100;
        cyc(); #1;
        check("t1_issue_valid", 80'(mem_in.mem_valid), 80'd1);
        check("t1_issue_instr", 80'(mem_in.mem_instr), 80'd1);
        check("t1_issue_addr", 80'(mem_in.mem_addr), 80'h100);
        cyc();
        mem_out.mem_ready = 1'b1;
        mem_out.mem_rdata = 32'h0000_0013;
        #1;
        check("t1_valid_one_cycle", 80'(mem_in.mem_valid), 80'd0);
        check("t1_resp_ready", 80'(imem_out.mem_ready), 80'd1);
        check("t1_resp_rdata", 80'(imem_out.mem_rdata), 80'h13);
        check("t1_dmem_quiet", 80'(dmem_out), 80'd0);
        cyc();
        idle_inputs();

        // Contention from IDLE with last_d=0: data first, then fetch
        imem_in.mem_valid = 1'b1;
        imem_in.mem_addr  = 32'h200;
        dmem_in.mem_valid = 1'b1;
        dmem_in.mem_addr  = 32'h8000;
        dmem_in.mem_wdata = 32'hDEAD_BEEF;
        dmem_in.mem_wstrb = 4'hF;
        cyc(); #1;
        check("t2_d_first_addr", 80'(mem_in.mem_addr), 80'h8000);
        check("t2_d_first_instr", 80'(mem_in.mem_instr), 80'd0);
        check("t2_d_first_wstrb", 80'(mem_in.mem_wstrb), 80'hF);
        cyc();
        mem_out.mem_ready = 1'b1;
        mem_out.mem_rdata = 32'hAA;
        #1;
        check("t2_d_resp", 80'(dmem_out.mem_rdata), 80'hAA);
        check("t2_i_not_resp", 80'(imem_out.mem_ready), 80'd0);
        cyc();
        dmem_in = '0;
        mem_out = '0;
        #1;
        check("t2_i_issue_valid", 80'(mem_in.mem_valid), 80'd1);
        check("t2_i_issue_addr", 80'(mem_in.mem_addr), 80'h200);
        cyc();
        mem_out.mem_ready = 1'b1;
        mem_out.mem_rdata = 32'h55;
        #1;
        check("t2_i_resp", 80'(imem_out.mem_rdata), 80'h55);
        cyc();
        idle_inputs();

        // Both requesters held valid, 1-cycle memory: grants must alternate D, I, D, I
        imem_in.mem_valid = 1'b1;
        imem_in.mem_addr  = 32'h300;
        dmem_in.mem_valid = 1'b1;
        dmem_in.mem_addr  = 32'h9000;
        g   = 0;
        seq = '0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (mem_in.mem_valid) begin
                if (g < 4) seq[g] = mem_in.mem_instr;
                g++;
                mem_out.mem_ready = 1'b1;
                mem_out.mem_rdata = 32'(k);
            end else begin
                mem_out = '0;
            end
        end
        check("t3_grant_order", 80'(seq), 80'b1010);
        check("t3_issue_every_cycle", 80'(g), 80'd8);
        cyc();
        imem_in = '0;
        dmem_in = '0;
        check("t3_tail_issue", 80'(mem_in.mem_valid), 80'd1);
        mem_out.mem_ready = mem_in.mem_valid;
        mem_out.mem_rdata = 32'h99;
        cyc();
        mem_out = '0;
        cyc();

        // Redirect kills the outstanding fetch; redirected address follows
        imem_in.mem_valid = 1'b1;
        imem_in.mem_addr  = 32'h100;
        cyc(); #1;
        check("t4_issue_addr", 80'(mem_in.mem_addr), 80'h100);
        imem_in.mem_spec = 1'b1;
        imem_in.mem_addr = 32'h400;
        cyc();
        mem_out.mem_ready = 1'b1;
        mem_out.mem_rdata = 32'h111;
        #1;
        check("t4_killed_not_fwd", 80'(imem_out.mem_ready), 80'd0);
        cyc();
        mem_out = '0;
        #1;
        check("t4_redirect_valid", 80'(mem_in.mem_valid), 80'd1);
        check("t4_redirect_addr", 80'(mem_in.mem_addr), 80'h400);
        cyc();
        mem_out.mem_ready = 1'b1;
        mem_out.mem_rdata = 32'h444;
        #1;
        check("t4_redirect_ready", 80'(imem_out.mem_ready), 80'd1);
        check("t4_redirect_rdata", 80'(imem_out.mem_rdata), 80'h444);
        cyc();
        idle_inputs();

        // Redirect in the same cycle as the response: response still forwarded
        imem_in.mem_valid = 1'b1;
        imem_in.mem_addr  = 32'h500;
        cyc();
        imem_in.mem_spec  = 1'b1;
        imem_in.mem_addr  = 32'h600;
        mem_out.mem_ready = 1'b1;
        mem_out.mem_rdata = 32'h5;
        #1;
        check("t4b_same_cycle_fwd", 80'(imem_out), 80'({1'b1, 32'h5}));
        cyc();
        idle_inputs();
        #1;
        check("t4b_no_reissue", 80'(mem_in.mem_valid), 80'd0);
        cyc();

        // Spec request matching the outstanding address does not kill
        imem_in.mem_valid = 1'b1;
        imem_in.mem_addr  = 32'h100;
        cyc();
        imem_in.mem_spec = 1'b1;
        cyc();
        mem_out.mem_ready = 1'b1;
        mem_out.mem_rdata = 32'h77;
        #1;
        check("t5_same_addr_fwd", 80'(imem_out), 80'({1'b1, 32'h77}));
        cyc();
        idle_inputs();
        cyc();

        // Reset during DWAIT, then a stray response after release
        dmem_in.mem_valid = 1'b1;
        dmem_in.mem_addr  = 32'h8000;
        dmem_in.mem_wstrb = 4'hF;
        cyc(); #1;
        check("t6_d_issued", 80'(mem_in.mem_valid), 80'd1);
        cyc();
        reset             = 1'b0;
        mem_out.mem_ready = 1'b1;
        mem_out.mem_rdata = 32'hBAD;
        #1;
        check("t6_gated_in_reset", 80'(dmem_out), 80'd0);
        cyc();
        reset   = 1'b1;
        dmem_in = '0;
        mem_out = '0;
        #1;
        check("t6_mem_in_cleared", 80'(mem_in), 80'd0);
        cyc();
        mem_out.mem_ready = 1'b1;
        mem_out.mem_rdata = 32'hBAD;
        #1;
        check("t6_stray_dmem", 80'(dmem_out), 80'd0);
        check("t6_stray_imem", 80'(imem_out), 80'd0);
        check("t6_stray_no_issue", 80'(mem_in), 80'd0);
        cyc();
        idle_inputs();
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
